// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the two-master memory port arbiter:
//               FSM state encoding, master index constants and a small
//               index-to-one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BUSY      = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  // Master indices: 0 = test controller, 1 = host/debug loader
  localparam logic M_TEST = 1'b0;
  localparam logic M_HOST = 1'b1;

  // Convert a master index into its one-hot grant vector
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : SRAM-style memory port bundle (address/byteenable/read/
//               write/writedata/readdata/readdataready/waitrequest).
//               modport master : the side issuing commands
//               modport slave  : the side accepting commands
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdataready;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdataready, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdataready, waitrequest
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_rr_pick2
// Description : Combinational two-way round-robin selector.
//   req[1:0] in  : request per master
//   last     in  : index of the master that was granted most recently
//   winner   out : index of the selected master (valid only when valid=1)
//   valid    out : at least one master is requesting
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid = |req;
  // On a tie the master that did not go last wins; otherwise the sole requester.
  assign winner = (&req) ? ~last : req[1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-master, one-slave arbiter for the external SRAM-style
//               memory port. Round-robin between masters with a bounded
//               write-burst hold, at most one read outstanding and a
//               sticky read-timeout flag.
// Ports:
//   clock       in  : system clock
//   reset_n     in  : asynchronous active-low reset
//   m0          slave modport  : master 0 (test controller)
//   m1          slave modport  : master 1 (host/debug loader)
//   s           master modport : memory side
//   grant       out : one-hot current owner, 00 when idle
//   timeout_err out : sticky read-timeout flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int HOLD_MAX   = 8,
  parameter int WAIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_port_arbiter_if.slave    m0,
  mem_port_arbiter_if.slave    m1,
  mem_port_arbiter_if.master   s,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  localparam int HOLD_WIDTH = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_MAX - 1);

  logic [1:0]            state;
  logic                  owner;     // meaningful in BUSY and WAIT_DATA only
  logic                  last;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [WAIT_WIDTH-1:0] wait_cnt;

  logic [1:0]            rd;
  logic [1:0]            wr;
  logic [1:0]            req;
  logic                  pick_winner;
  logic                  pick_valid;

  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [BE_WIDTH-1:0]   be_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  owner_rd;
  logic                  owner_wr;
  logic                  owner_req;
  logic                  other_req;
  logic                  busy;
  logic                  waiting;
  logic                  rd_accept;
  logic                  wr_accept;

  assign rd  = {m1.read,  m0.read};
  assign wr  = {m1.write, m0.write};
  assign req = rd | wr;

  mem_port_arbiter_rr_pick2 u_rr_pick2 (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Command path is a plain mux on the owner; the strobes are gated by state.
  always_comb begin
    addr_sel  = (owner == M_HOST) ? m1.address    : m0.address;
    be_sel    = (owner == M_HOST) ? m1.byteenable : m0.byteenable;
    wdata_sel = (owner == M_HOST) ? m1.writedata  : m0.writedata;
  end

  assign busy      = (state == BUSY);
  assign waiting   = (state == WAIT_DATA);
  assign owner_rd  = rd[owner];
  // A master asserting both read and write is treated as reading.
  assign owner_wr  = wr[owner] & ~rd[owner];
  assign owner_req = req[owner];
  assign other_req = req[~owner];

  assign s.address    = addr_sel;
  assign s.byteenable = be_sel;
  assign s.writedata  = wdata_sel;
  assign s.read       = busy & owner_rd;
  assign s.write      = busy & owner_wr;

  assign rd_accept = busy & owner_rd & ~s.waitrequest;
  assign wr_accept = busy & owner_wr & ~s.waitrequest;

  assign grant = (state == IDLE) ? 2'b00 : onehot2(owner);

  // Only the BUSY owner sees the memory's stall; everyone else is held off
  // for as long as it requests.
  assign m0.waitrequest = (busy && owner == M_TEST) ? s.waitrequest : req[0];
  assign m1.waitrequest = (busy && owner == M_HOST) ? s.waitrequest : req[1];

  // Read data is only routed while a read is actually outstanding, so late
  // responses in IDLE/BUSY are dropped.
  assign m0.readdataready = waiting && (owner == M_TEST) && s.readdataready;
  assign m1.readdataready = waiting && (owner == M_HOST) && s.readdataready;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= M_TEST;
      last        <= M_HOST;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BUSY;
            owner    <= pick_winner;
            last     <= pick_winner;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state <= IDLE;
          end else if (rd_accept) begin
            state    <= WAIT_DATA;
            wait_cnt <= '0;
          end else if (wr_accept) begin
            // Burst limit reached: yield only if the other master waits,
            // otherwise stay saturated and keep the grant.
            if (hold_cnt == HOLD_LAST) begin
              if (other_req) begin
                state <= IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (s.readdataready) begin
            state <= IDLE;
          end else if (&wait_cnt) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Randomized masters
//               and memory, checked every cycle against a reference model
//               of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int BW   = DW / 8;
  localparam int HOLD = 8;
  localparam int WW   = 4;
  localparam int TMO  = (1 << WW) - 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .HOLD_MAX   (HOLD),
    .WAIT_WIDTH (WW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  // master stimulus
  bit          act [2];
  bit          op_rd [2];
  bit          op_wr [2];
  logic [AW-1:0] op_addr [2];
  logic [BW-1:0] op_be [2];
  logic [DW-1:0] op_wd [2];

  // knobs (percentages)
  int p_req, p_rd, p_both, p_stall, p_late, lat_min, lat_max;
  bit no_resp;

  // memory model
  bit mem_pend;
  int mem_lat;

  // reference model: owner -1 means nobody holds the port
  int own, streak, waited, lastm;
  bit rdwait, tmo;

  // per-cycle expectations
  logic       exp_sr, exp_sw;
  logic [1:0] exp_grant;
  logic       exp_wait [2];
  logic       exp_rdy [2];
  logic       cur_sw, cur_srdy;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic start_op(input int i, input bit r, input bit w);
    act[i]     = 1'b1;
    op_rd[i]   = r;
    op_wr[i]   = w;
    op_addr[i] = AW'($urandom);
    op_be[i]   = BW'($urandom_range(3, 1));
    op_wd[i]   = DW'($urandom);
  endtask

  task automatic drive_masters();
    m0_bus.read       = act[0] & op_rd[0];
    m0_bus.write      = act[0] & op_wr[0];
    m0_bus.address    = op_addr[0];
    m0_bus.byteenable = op_be[0];
    m0_bus.writedata  = op_wd[0];
    m1_bus.read       = act[1] & op_rd[1];
    m1_bus.write      = act[1] & op_wr[1];
    m1_bus.address    = op_addr[1];
    m1_bus.byteenable = op_be[1];
    m1_bus.writedata  = op_wd[1];
  endtask

  task automatic model_reset();
    own = -1; streak = 0; waited = 0; lastm = 1; rdwait = 0; tmo = 0;
    mem_pend = 0; mem_lat = 0;
    act[0] = 0; act[1] = 0;
  endtask

  // One clock cycle: stimulus at the falling edge, compare 1 ns later,
  // then advance model/stimulus state just after the rising edge.
  task automatic do_cycle();
    int  r, o, w;
    bit  busy;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (!act[i] && $urandom_range(99) < p_req) begin
        r = $urandom_range(99);
        if (r < p_both)             start_op(i, 1'b1, 1'b1);
        else if (r < p_both + p_rd) start_op(i, 1'b1, 1'b0);
        else                        start_op(i, 1'b0, 1'b1);
      end
    end
    cur_sw   = ($urandom_range(99) < p_stall);
    cur_srdy = 1'b0;
    if (mem_pend) begin
      if (mem_lat == 0) begin
        cur_srdy = 1'b1;
        mem_pend = 0;
      end else begin
        mem_lat--;
      end
    end else begin
      cur_srdy = ($urandom_range(99) < p_late);
    end
    s_bus.waitrequest   = cur_sw;
    s_bus.readdataready = cur_srdy;
    s_bus.readdata      = DW'($urandom);
    drive_masters();
    #1;
    o    = (own < 0) ? 0 : own;
    busy = (own >= 0) && !rdwait;
    exp_grant = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    exp_sr = busy && act[o] && op_rd[o];
    exp_sw = busy && act[o] && op_wr[o] && !op_rd[o];
    for (int i = 0; i < 2; i++) begin
      exp_wait[i] = (busy && own == i) ? cur_sw : act[i];
      exp_rdy[i]  = (own == i) && rdwait && cur_srdy;
    end
    e_addr = op_addr[o]; e_be = op_be[o]; e_wd = op_wd[o];
    check_eq("grant",   64'(grant),            64'(exp_grant));
    check_eq("timeout", 64'(timeout_err),      64'(tmo));
    check_eq("s_read",  64'(s_bus.read),       64'(exp_sr));
    check_eq("s_write", 64'(s_bus.write),      64'(exp_sw));
    if (exp_sr || exp_sw) begin
      check_eq("s_addr", 64'(s_bus.address),    64'(e_addr));
      check_eq("s_be",   64'(s_bus.byteenable), 64'(e_be));
    end
    if (exp_sw) check_eq("s_wdata", 64'(s_bus.writedata), 64'(e_wd));
    check_eq("m0_wait", 64'(m0_bus.waitrequest),   64'(exp_wait[0]));
    check_eq("m1_wait", 64'(m1_bus.waitrequest),   64'(exp_wait[1]));
    check_eq("m0_rdy",  64'(m0_bus.readdataready), 64'(exp_rdy[0]));
    check_eq("m1_rdy",  64'(m1_bus.readdataready), 64'(exp_rdy[1]));
    if (exp_rdy[0]) check_eq("m0_rdata", 64'(m0_bus.readdata), 64'(s_bus.readdata));
    if (exp_rdy[1]) check_eq("m1_rdata", 64'(m1_bus.readdata), 64'(s_bus.readdata));

    @(posedge clock);
    if (own < 0) begin
      if (act[0] || act[1]) begin
        w      = (act[0] && act[1]) ? (1 - lastm) : (act[1] ? 1 : 0);
        own    = w;
        lastm  = w;
        streak = 0;
      end
    end else if (!rdwait) begin
      if (!act[own]) begin
        own = -1;
      end else if (!cur_sw) begin
        if (op_rd[own]) begin
          rdwait = 1;
          waited = 0;
          if (!no_resp) begin
            mem_pend = 1;
            mem_lat  = $urandom_range(lat_max, lat_min);
          end
        end else begin
          streak++;
          if (streak >= HOLD && act[1 - own]) own = -1;
        end
      end
    end else begin
      if (cur_srdy) begin
        own = -1; rdwait = 0;
      end else if (waited == TMO) begin
        tmo = 1; own = -1; rdwait = 0;
      end else begin
        waited++;
      end
    end
    for (int i = 0; i < 2; i++)
      if (act[i] && !exp_wait[i]) act[i] = 0;
  endtask

  task automatic set_knobs(input int rq, input int rdp, input int bth, input int stl,
                           input int lt, input int lmin, input int lmax, input bit nr);
    p_req = rq; p_rd = rdp; p_both = bth; p_stall = stl; p_late = lt;
    lat_min = lmin; lat_max = lmax; no_resp = nr;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) do_cycle();
  endtask

  initial begin
    model_reset();
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b0);
    s_bus.waitrequest = 1'b0; s_bus.readdataready = 1'b0; s_bus.readdata = '0;
    // reset state, with m0 requesting a read during reset
    start_op(0, 1'b1, 1'b0);
    drive_masters();
    #3;
    check_eq("rst_grant",   64'(grant),                64'(0));
    check_eq("rst_tmo",     64'(timeout_err),          64'(0));
    check_eq("rst_s_read",  64'(s_bus.read),           64'(0));
    check_eq("rst_s_write", 64'(s_bus.write),          64'(0));
    check_eq("rst_m0_wait", 64'(m0_bus.waitrequest),   64'(1));
    check_eq("rst_m1_wait", 64'(m1_bus.waitrequest),   64'(0));
    check_eq("rst_m0_rdy",  64'(m0_bus.readdataready), 64'(0));
    act[0] = 0;
    drive_masters();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // single m0 write
    start_op(0, 1'b0, 1'b1);
    run(4);
    // both masters write continuously: 8/idle/8 alternation
    set_knobs(100, 0, 0, 0, 0, 0, 0, 1'b0);
    run(45);
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b0);
    run(3);
    // both masters read, data 3 cycles after accept
    set_knobs(100, 100, 0, 0, 0, 2, 2, 1'b0);
    run(30);
    set_knobs(0, 0, 0, 0, 0, 2, 2, 1'b0);
    run(8);
    // m1 write stalled by memory for 5 cycles
    start_op(1, 1'b0, 1'b1);
    set_knobs(0, 0, 0, 100, 0, 0, 0, 1'b0);
    run(6);
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b0);
    run(3);
    // random traffic
    set_knobs(40, 40, 5, 30, 5, 0, 4, 1'b0);
    run(2500);
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b0);
    run(10);
    // read timeout, then a late response pulse
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b1);
    start_op(0, 1'b1, 1'b0);
    run(22);
    #1;
    check_eq("tmo_flag",  64'(timeout_err), 64'(1));
    check_eq("tmo_grant", 64'(grant),       64'(0));
    set_knobs(0, 0, 0, 0, 100, 0, 0, 1'b1);
    run(2);
    // async reset in the middle of WAIT_DATA
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b1);
    start_op(0, 1'b1, 1'b0);
    for (int k = 0; k < 10 && !rdwait; k++) do_cycle();
    run(1);
    #1;
    check_eq("in_wait_grant", 64'(grant), 64'(1));
    @(negedge clock);
    s_bus.readdataready = 1'b1;
    #1;
    check_eq("pre_rst_rdy", 64'(m0_bus.readdataready), 64'(1));
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_grant", 64'(grant),                64'(0));
    check_eq("arst_rd",    64'(s_bus.read),           64'(0));
    check_eq("arst_wr",    64'(s_bus.write),          64'(0));
    check_eq("arst_rdy",   64'(m0_bus.readdataready), 64'(0));
    check_eq("arst_tmo",   64'(timeout_err),          64'(0));
    model_reset();
    s_bus.readdataready = 1'b0;
    drive_masters();
    @(negedge clock);
    reset_n = 1'b1;
    // first tie after reset goes to m0
    set_knobs(0, 0, 0, 0, 0, 0, 0, 1'b0);
    start_op(0, 1'b0, 1'b1);
    start_op(1, 1'b0, 1'b1);
    run(1);
    #1;
    check_eq("tie_m0", 64'(grant), 64'(1));
    run(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
